// File: rtl/serdes_align_pkg.sv
// Shared types, widths and the byte-rotate helper for the deserializer
// word-alignment controller.
package serdes_align_pkg;

  localparam int unsigned LANE_W = 8;
  localparam int unsigned ROT_W  = 3;

  typedef enum logic [2:0] {
    RST_SERDES,
    WAIT_RDY,
    SETTLE,
    SCAN,
    DONE,
    FAIL
  } align_state_t;

  // Right-rotate an 8-bit word: low byte of {w,w} >> r.
  function automatic logic [LANE_W-1:0] rotr8(input logic [LANE_W-1:0] w,
                                              input logic [ROT_W-1:0]  r);
    logic [2*LANE_W-1:0] ww;
    ww = {w, w} >> r;
    return ww[LANE_W-1:0];
  endfunction

endpackage

// File: rtl/lane_rotate.sv
// Registered 8-bit rotator: one per lane, applies the stored rotation.
module lane_rotate
  import serdes_align_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [LANE_W-1:0] word,
  input  logic [ROT_W-1:0]  rot,
  output logic [LANE_W-1:0] rot_word
);

  logic [LANE_W-1:0] word_q;
  logic [LANE_W-1:0] word_d;

  always_comb begin
    word_d = rotr8(word, rot);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign rot_word = word_q;

endmodule

// File: rtl/serdes_align_ctrl.sv
// Deserializer startup sequencer and per-lane word-alignment controller:
// reset, IDELAY wait, training settle, per-lane rotation scan, realigned bus.
module serdes_align_ctrl
  import serdes_align_pkg::*;
#(
  parameter int unsigned       LANES         = 32,
  parameter logic [LANE_W-1:0] PATTERN       = 8'hF0,
  parameter int unsigned       RST_CYCLES    = 16,
  parameter int unsigned       SETTLE_CYCLES = 64,
  parameter int unsigned       MATCH_COUNT   = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    idelay_rdy,
  input  logic                    start,
  input  logic [LANES*LANE_W-1:0] sample,
  output logic                    serdes_reset,
  output logic                    train_req,
  output logic [LANES*LANE_W-1:0] aligned_sample,
  output logic [LANES-1:0]        lane_ok,
  output logic                    aligned,
  output logic                    error,
  output logic                    busy
);

  localparam int unsigned TIMER_MAX  = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TIMER_W    = $clog2(TIMER_MAX + 1);
  localparam int unsigned LANE_CNT_W = $clog2(LANES + 1);
  localparam int unsigned LANE_IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned MATCH_W    = $clog2(MATCH_COUNT + 1);

  align_state_t                  state_q, state_d;
  logic [TIMER_W-1:0]            timer_q, timer_d;
  logic [LANE_CNT_W-1:0]         lane_q, lane_d;
  logic [ROT_W-1:0]              rot_q, rot_d;
  logic [MATCH_W-1:0]            match_q, match_d;
  logic [LANES-1:0][ROT_W-1:0]   rot_tab_q, rot_tab_d;
  logic [LANES-1:0]              lane_ok_q, lane_ok_d;
  logic                          serdes_reset_q, serdes_reset_d;
  logic                          train_req_q, train_req_d;
  logic                          aligned_q, aligned_d;
  logic                          error_q, error_d;

  logic [LANES-1:0][LANE_W-1:0]  lanes_w;
  logic [LANE_IDX_W-1:0]         lane_idx;
  logic [LANE_W-1:0]             cur_word;
  logic                          scan_hit;
  logic                          restart;

  assign lanes_w  = sample;
  assign lane_idx = lane_q[LANE_IDX_W-1:0];
  assign cur_word = lanes_w[lane_idx];
  assign scan_hit = (rotr8(cur_word, rot_q) == PATTERN);

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    lane_d         = lane_q;
    rot_d          = rot_q;
    match_d        = match_q;
    rot_tab_d      = rot_tab_q;
    lane_ok_d      = lane_ok_q;
    serdes_reset_d = serdes_reset_q;
    train_req_d    = train_req_q;
    aligned_d      = aligned_q;
    error_d        = error_q;
    restart        = 1'b0;

    case (state_q)
      RST_SERDES: begin
        serdes_reset_d = 1'b1;
        train_req_d    = 1'b0;
        if (timer_q == TIMER_W'(RST_CYCLES - 1)) begin
          state_d        = WAIT_RDY;
          serdes_reset_d = 1'b0;
          timer_d        = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_RDY: begin
        if (idelay_rdy) begin
          state_d     = SETTLE;
          train_req_d = 1'b1;
          timer_d     = '0;
        end
      end
      SETTLE: begin
        if (!idelay_rdy) begin
          restart = 1'b1;
        end else if (timer_q == TIMER_W'(SETTLE_CYCLES - 1)) begin
          state_d = SCAN;
          timer_d = '0;
          lane_d  = '0;
          rot_d   = '0;
          match_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      SCAN: begin
        if (!idelay_rdy) begin
          restart = 1'b1;
        end else if (lane_q == LANE_CNT_W'(LANES)) begin
          // Every lane visited: one extra cycle to settle the verdict.
          train_req_d = 1'b0;
          if (&lane_ok_q) begin
            state_d   = DONE;
            aligned_d = 1'b1;
          end else begin
            state_d = FAIL;
            error_d = 1'b1;
          end
        end else if (scan_hit) begin
          if (match_q == MATCH_W'(MATCH_COUNT - 1)) begin
            rot_tab_d[lane_idx] = rot_q;
            lane_ok_d[lane_idx] = 1'b1;
            lane_d              = lane_q + 1'b1;
            rot_d               = '0;
            match_d             = '0;
          end else begin
            match_d = match_q + 1'b1;
          end
        end else begin
          match_d = '0;
          if (rot_q == ROT_W'(LANE_W - 1)) begin
            lane_d = lane_q + 1'b1;
            rot_d  = '0;
          end else begin
            rot_d = rot_q + 1'b1;
          end
        end
      end
      DONE, FAIL: begin
        train_req_d = 1'b0;
        if (start) begin
          restart = 1'b1;
        end
      end
      default: begin
        restart = 1'b1;
      end
    endcase

    // Any restart drops back to deserializer reset with results cleared.
    if (restart) begin
      state_d        = RST_SERDES;
      timer_d        = '0;
      lane_d         = '0;
      rot_d          = '0;
      match_d        = '0;
      rot_tab_d      = '0;
      lane_ok_d      = '0;
      serdes_reset_d = 1'b1;
      train_req_d    = 1'b0;
      aligned_d      = 1'b0;
      error_d        = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= RST_SERDES;
      timer_q        <= '0;
      lane_q         <= '0;
      rot_q          <= '0;
      match_q        <= '0;
      rot_tab_q      <= '0;
      lane_ok_q      <= '0;
      serdes_reset_q <= 1'b1;
      train_req_q    <= 1'b0;
      aligned_q      <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      lane_q         <= lane_d;
      rot_q          <= rot_d;
      match_q        <= match_d;
      rot_tab_q      <= rot_tab_d;
      lane_ok_q      <= lane_ok_d;
      serdes_reset_q <= serdes_reset_d;
      train_req_q    <= train_req_d;
      aligned_q      <= aligned_d;
      error_q        <= error_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_rotate u_lane_rotate (
      .clock    (clock),
      .reset    (reset),
      .word     (sample[i*LANE_W +: LANE_W]),
      .rot      (rot_tab_q[i]),
      .rot_word (aligned_sample[i*LANE_W +: LANE_W])
    );
  end

  assign serdes_reset = serdes_reset_q;
  assign train_req    = train_req_q;
  assign lane_ok      = lane_ok_q;
  assign aligned      = aligned_q;
  assign error        = error_q;
  assign busy         = (state_q != DONE) && (state_q != FAIL);

endmodule

// File: doc/serdes_align_ctrl.md
# serdes_align_ctrl

Startup sequencer and word-alignment controller for the 32-lane, 1:8 deserializer wrapper. It holds the deserializer in reset, waits for IDELAY readiness, and requests the ADC training pattern. It then scans each lane for the rotation that recovers the pattern, stores one rotation per lane, and outputs the realigned 256-bit sample bus to downstream framing logic. It runs in the deserializer's divided clock domain.

## Interface
- `LANES`, 32: number of 8-bit lanes.
- `PATTERN`, 8'hF0: training word. All 8 rotations must be distinct.
- `RST_CYCLES`, 16: cycles `serdes_reset` is held high per sequence.
- `SETTLE_CYCLES`, 64: cycles waited after `idelay_rdy` before scanning.
- `MATCH_COUNT`, 16: consecutive matches needed to accept a rotation.
- `clock` in 1: divided deserializer clock. All logic runs on its rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-high.
- `idelay_rdy` in 1: IDELAYCTRL ready.
- `start` in 1: single-cycle pulse that requests realignment.
- `sample` in 256: raw deserializer words. Lane i is `sample[8i+7:8i]`.
- `serdes_reset` out 1: drives the deserializer reset.
- `train_req` out 1: requests ADC test-pattern mode.
- `aligned_sample` out 256: per-lane rotated data, registered.
- `lane_ok` out 32: per-lane alignment success.
- `aligned` out 1: all lanes aligned.
- `error` out 1: at least one lane failed.
- `busy` out 1: a sequence is in progress.

## Operation
- States: RST_SERDES, WAIT_RDY, SETTLE, SCAN, DONE, FAIL.
- While `reset` is high:
  - State is RST_SERDES, timer = 0.
  - `serdes_reset`=1, `train_req`=0, `busy`=1.
  - `aligned`=0, `error`=0.
  - `lane_ok`=0, `aligned_sample`=0.
  - All stored rotations = 0.
- RST_SERDES: `serdes_reset`=1 for RST_CYCLES cycles, then go to WAIT_RDY.
- WAIT_RDY: `serdes_reset`=0. Stay until `idelay_rdy`=1, then go to SETTLE.
- SETTLE: `train_req`=1. Count SETTLE_CYCLES, then go to SCAN with lane=0, rot=0, match counter=0.
- SCAN, lanes in order 0..LANES-1:
  - Compare `rotr(lane word, rot)` with PATTERN every cycle.
  - `rotr(w,r)` = low 8 bits of `{w,w} >> r`.
  - Match: counter increments. When it reaches MATCH_COUNT, store rot for the lane, set `lane_ok[lane]`, advance the lane, and clear rot and counter.
  - Mismatch: counter clears and rot increments.
  - Mismatch at rot=7: lane fails, `lane_ok[lane]` stays 0, stored rot stays 0, advance the lane.
- After the last lane:
  - All `lane_ok` set: go to DONE with `aligned`=1.
  - Otherwise: go to FAIL with `error`=1.
- DONE/FAIL: `train_req`=0, `busy`=0. Rotations and `lane_ok` are held.
- `start` in DONE/FAIL: clear `lane_ok`, `aligned`, `error` and all rotations, then go to RST_SERDES. `start` in any other state is ignored.
- `idelay_rdy` falling in SETTLE or SCAN: go to RST_SERDES and clear partial results.
- `aligned_sample`: lane i is `rotr(sample lane i, stored rot i)`, registered. It updates every cycle in every state.

## Timing
- `aligned_sample` has 1-cycle latency from `sample`.
- A rotation update takes effect on the next cycle's output.
- Fastest sequence, all lanes matching at rot 0, from reset release to `aligned`=1:
  - RST_CYCLES + 1 (WAIT_RDY, with `idelay_rdy` already high)
  - + SETTLE_CYCLES
  - + LANES×MATCH_COUNT
  - + 1
  - With defaults: 16+1+64+512+1 = 594 cycles.
- Worst case per lane is 8×MATCH_COUNT cycles plus interleaved mismatches. The scan is bounded and never deadlocks.
- `lane_ok[lane]` asserts in the cycle after the MATCH_COUNT-th consecutive match.
- Outputs are registered except `busy`, which is decoded from state.

## Structure
- Package `serdes_align_pkg` holds:
  - the state enum `align_state_t`
  - constants `LANE_W`=8 and `ROT_W`=3
  - function `rotr8(logic [7:0] w, logic [2:0] r)`
- Sub-module `lane_rotate`: registered 8-bit rotator, instantiated LANES times by generate. Inputs: word and rot. Output: registered word.
- The FSM, timers, lane/rot/match counters and the rotation register file (LANES×3 bits) stay in `serdes_align_ctrl`.

## Test plan
- Every lane carries 8'hF0 from reset release, `idelay_rdy`=1:
  - `serdes_reset` is high for 16 cycles.
  - `aligned`=1 at cycle 594.
  - `lane_ok`=32'hFFFF_FFFF, all rotations 0.
  - `aligned_sample` lanes = 8'hF0.
- Lane 5 carries 8'h87 (F0 rotated left by 3), other lanes 8'hF0:
  - Lane 5 stores rot 3.
  - `aligned_sample[47:40]`=8'hF0.
  - `aligned`=1.
- Lane 31 carries constant 8'h00:
  - `lane_ok[31]`=0, others 1.
  - FAIL state reached, `error`=1, `aligned`=0.
- Deassert `idelay_rdy` mid-SCAN (lane 10):
  - `serdes_reset` reasserts for 16 cycles.
  - `lane_ok` clears, then a full realignment completes.
- `start` pulse during SCAN is ignored.
- `start` pulse in DONE:
  - `aligned` drops next cycle, `busy`=1.
  - Full sequence repeats with the same 594-cycle timing.
- Assert `reset` asynchronously mid-SETTLE, between clock edges:
  - All outputs take their reset values immediately.
